lsu_dmem_if: RTL and testbench
==============================

# lsu_dmem_if

Load/store unit between the control/ALU stage and the data memory. It consumes `mem_rden`, `mem_wren`, `l_sel` and `s_sel` from the control unit, plus the ALU address and rs2 data. It runs a multi-cycle request/acknowledge transaction to data memory, stalling the core until the access completes. For stores it generates byte enables and lane-replicated write data; for loads it extracts, sign- or zero-extends and registers the data for writeback.

## Interface
- `TIMEOUT`, 15: maximum cycles in REQ without `dmem_ack` before aborting (1..255).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_rden`  in  1  load request from control unit.
- `mem_wren`  in  1  store request from control unit.
- `l_sel`  in  3  load type: 001 LB, 010 LH, 011 LBU, 100 LHU, 101 LW, 000 none.
- `s_sel`  in  2  store type: 01 SB, 10 SH, 11 SW, 00 none.
- `addr`  in  32  byte address (ALU result).
- `st_data`  in  32  store data (rs2).
- `ld_data`  out  32  formatted load result, registered.
- `ld_valid`  out  1  one-cycle pulse: `ld_data` valid for writeback.
- `stall`  out  1  hold PC/pipeline while high.
- `fault`  out  2  registered, valid in DONE: 00 ok, 01 misaligned, 10 timeout, 11 conflicting request.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address (`addr[1:0]` forced to 00).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  write data.
- `dmem_ack`  in  1  memory completion; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - `stall = mem_rden | mem_wren`.
  - On a request, the next edge captures `addr`, `st_data`, `l_sel`, `s_sel`, direction, and the computed be/wdata.
  - Legal, aligned access: go to REQ.
  - Misaligned access (halfword with `addr[0]=1`, word with `addr[1:0]≠00`): go to DONE with fault=01.
  - Both `mem_rden` and `mem_wren` high: go to DONE with fault=11.
  - Faulted accesses issue no `dmem_req`.
- **REQ**
  - `dmem_req=1`, `stall=1`. All dmem outputs come from the captured registers and stay stable until ack.
  - On `dmem_ack`: go to DONE with fault=00. For loads, capture the formatted `dmem_rdata` into `ld_data`.
- **DONE**
  - `stall=0`, `dmem_req=0`. `ld_valid=1` only for a successful load.
  - Always return to IDLE. Requests are not sampled in DONE; the core advances at the end of this cycle.
- **Store formatting**
  - SB: `be = 0001 << addr[1:0]`, `wdata = {4{st_data[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{st_data[15:0]}}`.
  - SW: `be = 1111`, `wdata = st_data`.
- **Load formatting**
  - Select the byte lane by `addr[1:0]` or the halfword by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- On a fault, `ld_data` is cleared to 0.
- Illegal `l_sel`/`s_sel` (000/00) with the matching enable high is treated as a misaligned-class fault (01).

## Timing
- Minimum access: 3 cycles (IDLE detect, REQ with same-cycle ack, DONE). Each wait cycle in REQ adds one.
- A faulted access takes 2 cycles (IDLE, DONE).
- `stall` is combinational from state and inputs. It is forced to 0 while `rst` is high.
- Reset values: state IDLE, all outputs 0, captured registers 0, timeout counter 0.
- Reset asserted mid-REQ: `dmem_req` drops asynchronously, with no completion or `ld_valid`.
- The timeout counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches `TIMEOUT`, the FSM goes to DONE with fault=10 and `dmem_req` is dropped.
- Ack arriving in the same cycle the counter reaches `TIMEOUT`: ack wins, fault=00.
- `dmem_ack` outside REQ is ignored.

## Configuration
- **`LSU_TIMEOUT_EN` defined**: the timeout counter and fault code 10 are implemented as described.
- **Not defined**: no counter is synthesized, REQ waits indefinitely for `dmem_ack`, `fault` never reports 10, and `TIMEOUT` is ignored.

## Test plan
- LB: `addr=0x103`, `dmem_rdata=0x80FF_FFFF`, ack in the first REQ cycle → `dmem_addr=0x100`, `be=1111`, `we=0`; `ld_data=0xFFFF_FF80`, `ld_valid=1` for one cycle; `stall` high for exactly 2 cycles.
- LHU: `addr=0x202`, `dmem_rdata=0x9ABC_1234` → `ld_data=0x0000_9ABC`, fault=00.
- SH: `addr=0x102`, `st_data=0x1234_ABCD` → `dmem_we=1`, `be=1100`, `wdata=0xABCD_ABCD`; `ld_valid` stays 0.
- LW at `addr=0x101` → no `dmem_req`; DONE with fault=01, `ld_data=0`; `stall` high for 1 cycle. Both enables high → fault=11.
- Ack delayed 3 cycles with `addr`/`st_data` inputs changing → dmem outputs stay stable and `stall` stays high throughout. With `LSU_TIMEOUT_EN` and `TIMEOUT=4`, no ack → fault=10 after 4 REQ cycles and `req` drops.
- `rst` pulsed mid-REQ → `dmem_req`, `stall`, `ld_valid` go to 0 immediately; the next load after reset completes normally.

Source files
------------

// File: rtl/lsu_dmem_if_if.sv
// ---------------------------------------------------------------------------
// lsu_dmem_if_if
// Data-memory bus between the load/store unit and the data memory.
//   dmem_req    : access request, held until dmem_ack
//   dmem_we     : 1 = write, 0 = read
//   dmem_addr   : word-aligned byte address
//   dmem_be     : byte enables (bit n = byte lane n)
//   dmem_wdata  : lane-replicated write data
//   dmem_ack    : access complete; dmem_rdata valid in the same cycle
//   dmem_rdata  : read data word
// Modports: master = load/store unit, slave = data memory.
// ---------------------------------------------------------------------------
interface lsu_dmem_if_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_dmem_if.sv
// ---------------------------------------------------------------------------
// lsu_dmem_if
// Load/store unit between the control/ALU stage and data memory. Runs a
// request/acknowledge transaction (IDLE -> REQ -> DONE), stalling the core
// until the access completes. Stores get byte enables and lane-replicated
// data; loads are lane-selected, sign/zero-extended and registered.
//
// Parameter TIMEOUT : max REQ cycles without dmem_ack before abort (1..255).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   mem_rden/mem_wren : load / store request from control
//   l_sel / s_sel     : load type / store type
//   addr, st_data     : byte address, store data (rs2)
//   ld_data, ld_valid : registered load result, one-cycle valid pulse
//   stall             : hold the pipeline while high (combinational)
//   fault             : 00 ok, 01 misaligned/illegal, 10 timeout, 11 conflict
//   dmem              : data-memory bus (master side)
//
// Build option: define LSU_TIMEOUT_EN to implement the REQ timeout counter
// and fault code 10. Without it REQ waits indefinitely for dmem_ack.
// ---------------------------------------------------------------------------
module lsu_dmem_if #(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_rden,
    input  logic                 mem_wren,
    input  logic [2:0]           l_sel,
    input  logic [1:0]           s_sel,
    input  logic [31:0]          addr,
    input  logic [31:0]          st_data,
    output logic [31:0]          ld_data,
    output logic                 ld_valid,
    output logic                 stall,
    output logic [1:0]           fault,
    lsu_dmem_if_if.master        dmem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reject out-of-range configurations at elaboration.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("lsu_dmem_if: TIMEOUT must be in 1..255");
    end

    // Byte enables for a store; loads always read the full word.
    function automatic logic [3:0] store_be(input logic [1:0] sel, input logic [1:0] lane);
        case (sel)
            2'b01:   store_be = 4'b0001 << lane;
            2'b10:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the access may hit.
    function automatic logic [31:0] store_wdata(input logic [1:0] sel, input logic [31:0] d);
        case (sel)
            2'b01:   store_wdata = {4{d[7:0]}};
            2'b10:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Lane select plus sign/zero extension of a read word.
    function automatic logic [31:0] load_format(input logic [2:0] sel, input logic [1:0] lane,
                                                input logic [31:0] rd);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rd >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? rd[31:16] : rd[15:0];
        case (sel)
            3'b001:  load_format = {{24{b[7]}}, b};
            3'b010:  load_format = {{16{h[15]}}, h};
            3'b011:  load_format = {24'd0, b};
            3'b100:  load_format = {16'd0, h};
            3'b101:  load_format = rd;
            default: load_format = 32'd0;
        endcase
    endfunction

    // Misaligned access or an illegal type code for the active direction.
    function automatic logic access_bad(input logic is_load, input logic [2:0] ls,
                                        input logic [1:0] ss, input logic [1:0] lane);
        if (is_load) begin
            case (ls)
                3'b001, 3'b011: access_bad = 1'b0;
                3'b010, 3'b100: access_bad = lane[0];
                3'b101:         access_bad = (lane != 2'b00);
                default:        access_bad = 1'b1;
            endcase
        end else begin
            case (ss)
                2'b01:   access_bad = 1'b0;
                2'b10:   access_bad = lane[0];
                2'b11:   access_bad = (lane != 2'b00);
                default: access_bad = 1'b1;
            endcase
        end
    endfunction

    state_t      state_r, state_n;
    logic [31:0] addr_r, wdata_r, ld_data_r;
    logic [3:0]  be_r;
    logic [1:0]  lane_r, fault_r;
    logic [2:0]  l_sel_r;
    logic        we_r, ld_valid_r;

    logic        stall_s, capture_s, enter_done_s, load_ok_s, timeout_s;
    logic [1:0]  done_fault_s;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_r;

    // Timeout counter: zero outside REQ, counts REQ cycles without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (state_r != ST_REQ) begin
            cnt_r <= 8'd0;
        end else if (!dmem.dmem_ack) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign timeout_s = (cnt_r == TO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and transaction control decode.
    always_comb begin
        state_n      = state_r;
        stall_s      = 1'b0;
        capture_s    = 1'b0;
        enter_done_s = 1'b0;
        load_ok_s    = 1'b0;
        done_fault_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                stall_s = mem_rden | mem_wren;
                if (mem_rden | mem_wren) begin
                    capture_s = 1'b1;
                    if (mem_rden && mem_wren) begin
                        state_n      = ST_DONE;
                        enter_done_s = 1'b1;
                        done_fault_s = 2'b11;
                    end else if (access_bad(mem_rden, l_sel, s_sel, addr[1:0])) begin
                        state_n      = ST_DONE;
                        enter_done_s = 1'b1;
                        done_fault_s = 2'b01;
                    end else begin
                        state_n = ST_REQ;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                // Ack is tested first so it wins over a simultaneous timeout.
                if (dmem.dmem_ack) begin
                    state_n      = ST_DONE;
                    enter_done_s = 1'b1;
                    load_ok_s    = ~we_r;
                end else if (timeout_s) begin
                    state_n      = ST_DONE;
                    enter_done_s = 1'b1;
                    done_fault_s = 2'b10;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            be_r       <= 4'd0;
            lane_r     <= 2'd0;
            l_sel_r    <= 3'd0;
            we_r       <= 1'b0;
            ld_data_r  <= 32'd0;
            ld_valid_r <= 1'b0;
            fault_r    <= 2'b00;
        end else begin
            state_r    <= state_n;
            ld_valid_r <= load_ok_s;
            if (capture_s) begin
                addr_r  <= {addr[31:2], 2'b00};
                lane_r  <= addr[1:0];
                l_sel_r <= l_sel;
                we_r    <= mem_wren;
                be_r    <= mem_wren ? store_be(s_sel, addr[1:0]) : 4'b1111;
                wdata_r <= store_wdata(s_sel, st_data);
            end
            if (enter_done_s) begin
                fault_r <= done_fault_s;
                if (done_fault_s != 2'b00) begin
                    ld_data_r <= 32'd0;
                end else if (load_ok_s) begin
                    ld_data_r <= load_format(l_sel_r, lane_r, dmem.dmem_rdata);
                end
            end
        end
    end

    // Stall must not hold the core while it is being reset.
    assign stall            = stall_s & ~rst;
    assign ld_data          = ld_data_r;
    assign ld_valid         = ld_valid_r;
    assign fault            = fault_r;
    assign dmem.dmem_req    = (state_r == ST_REQ);
    assign dmem.dmem_we     = we_r;
    assign dmem.dmem_addr   = addr_r;
    assign dmem.dmem_be     = be_r;
    assign dmem.dmem_wdata  = wdata_r;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_if
// Directed, table-driven bench for lsu_dmem_if (TIMEOUT = 4), with
// hand-written sequences for reset, timeout and stray-ack corner cases.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rden, mem_wren;
    logic [2:0]  l_sel;
    logic [1:0]  s_sel;
    logic [31:0] addr, st_data;
    logic [31:0] ld_data;
    logic        ld_valid, stall;
    logic [1:0]  fault;

    int checks = 0;
    int errors = 0;

    lsu_dmem_if_if bus();

    lsu_dmem_if #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rden (mem_rden),
        .mem_wren (mem_wren),
        .l_sel    (l_sel),
        .s_sel    (s_sel),
        .addr     (addr),
        .st_data  (st_data),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .stall    (stall),
        .fault    (fault),
        .dmem     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rden;
        logic        wren;
        logic [2:0]  ls;
        logic [1:0]  ss;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdat;
        int          dly;
        logic [1:0]  f;
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] ls,
                                input logic [1:0] ss, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rdat, input int dly,
                                input logic [1:0] f, input logic [31:0] daddr,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] ld);
        vec_t v;
        v.rden = rd; v.wren = wr; v.ls = ls; v.ss = ss; v.a = a; v.sd = sd;
        v.rdat = rdat; v.dly = dly; v.f = f; v.daddr = daddr; v.be = be;
        v.wd = wd; v.ld = ld;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one access and check every phase of it.
    task automatic run_vec(input vec_t v, input int idx);
        int    stall_cnt;
        string p;
        p = $sformatf("v%0d", idx);
        stall_cnt = 0;
        @(negedge clk);
        mem_rden = v.rden; mem_wren = v.wren; l_sel = v.ls; s_sel = v.ss;
        addr = v.a; st_data = v.sd; bus.dmem_ack = 1'b0;
        #1;
        if (stall) stall_cnt++;
        @(negedge clk);
        if (v.f != 2'b00) begin
            chk({p, " no_req"}, {31'd0, bus.dmem_req}, 32'd0);
        end else begin
            for (int k = 0; k <= v.dly; k++) begin
                chk({p, " req"},   {31'd0, bus.dmem_req}, 32'd1);
                chk({p, " daddr"}, bus.dmem_addr, v.daddr);
                chk({p, " be"},    {28'd0, bus.dmem_be}, {28'd0, v.be});
                chk({p, " we"},    {31'd0, bus.dmem_we}, {31'd0, v.wren});
                if (v.wren) chk({p, " wdata"}, bus.dmem_wdata, v.wd);
                if (stall) stall_cnt++;
                if (k == v.dly) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = v.rdat;
                end else begin
                    addr           = $urandom;
                    st_data        = $urandom;
                    bus.dmem_rdata = $urandom;
                end
                @(negedge clk);
            end
            bus.dmem_ack = 1'b0;
        end
        // DONE cycle
        mem_rden = 1'b0; mem_wren = 1'b0;
        #1;
        if (stall) stall_cnt++;
        chk({p, " done_req"},   {31'd0, bus.dmem_req}, 32'd0);
        chk({p, " fault"},      {30'd0, fault}, {30'd0, v.f});
        chk({p, " ld_valid"},   {31'd0, ld_valid}, {31'd0, (v.rden && !v.wren && v.f == 2'b00)});
        if (v.rden || v.f != 2'b00) chk({p, " ld_data"}, ld_data, v.ld);
        chk({p, " stall_cycles"}, stall_cnt, (v.f != 2'b00) ? 32'd1 : 32'(2 + v.dly));
        @(negedge clk);
        chk({p, " ld_valid_pulse"}, {31'd0, ld_valid}, 32'd0);
        chk({p, " idle_req"},       {31'd0, bus.dmem_req}, 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(1, 0, 3'b001, 2'b00, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 2'b00, 32'h100, 4'hF, 32'h0, 32'hFFFF_FF80);
        vecs[1]  = mk(1, 0, 3'b100, 2'b00, 32'h202, 32'h0, 32'h9ABC_1234, 0, 2'b00, 32'h200, 4'hF, 32'h0, 32'h0000_9ABC);
        vecs[2]  = mk(1, 1, 3'b101, 2'b11, 32'h100, 32'h0, 32'h0,         0, 2'b11, 32'h0,   4'h0, 32'h0, 32'h0);
        vecs[3]  = mk(1, 0, 3'b001, 2'b00, 32'h300, 32'h0, 32'h0000_007F, 0, 2'b00, 32'h300, 4'hF, 32'h0, 32'h0000_007F);
        vecs[4]  = mk(1, 0, 3'b101, 2'b00, 32'h101, 32'h0, 32'h0,         0, 2'b01, 32'h0,   4'h0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 1, 3'b000, 2'b10, 32'h102, 32'h1234_ABCD, 32'h0, 0, 2'b00, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0);
        vecs[6]  = mk(0, 1, 3'b000, 2'b01, 32'h201, 32'h0000_00A5, 32'h0, 3, 2'b00, 32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        vecs[7]  = mk(1, 0, 3'b010, 2'b00, 32'h302, 32'h0, 32'h8001_FFFF, 1, 2'b00, 32'h300, 4'hF, 32'h0, 32'hFFFF_8001);
        vecs[8]  = mk(1, 0, 3'b011, 2'b00, 32'h301, 32'h0, 32'h1122_C344, 0, 2'b00, 32'h300, 4'hF, 32'h0, 32'h0000_00C3);
        vecs[9]  = mk(0, 1, 3'b000, 2'b10, 32'h103, 32'h5555_6666, 32'h0, 0, 2'b01, 32'h0,   4'h0, 32'h0, 32'h0);
        vecs[10] = mk(1, 0, 3'b101, 2'b00, 32'h400, 32'h0, 32'hDEAD_BEEF, 3, 2'b00, 32'h400, 4'hF, 32'h0, 32'hDEAD_BEEF);
        vecs[11] = mk(1, 0, 3'b000, 2'b00, 32'h000, 32'h0, 32'h0,         0, 2'b01, 32'h0,   4'h0, 32'h0, 32'h0);
        vecs[12] = mk(0, 1, 3'b000, 2'b11, 32'h404, 32'hCAFE_F00D, 32'h0, 0, 2'b00, 32'h404, 4'hF, 32'hCAFE_F00D, 32'h0);
        vecs[13] = mk(0, 1, 3'b000, 2'b01, 32'h503, 32'h1234_5678, 32'h0, 0, 2'b00, 32'h500, 4'b1000, 32'h7878_7878, 32'h0);
        vecs[14] = mk(1, 0, 3'b100, 2'b00, 32'h500, 32'h0, 32'hFFFF_8765, 0, 2'b00, 32'h500, 4'hF, 32'h0, 32'h0000_8765);

        // Reset state; a pending request must not raise stall during reset.
        rst = 1'b1; mem_rden = 1'b1; mem_wren = 1'b0; l_sel = 3'b101; s_sel = 2'b00;
        addr = 32'h0; st_data = 32'h0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        #3;
        chk("rst stall",    {31'd0, stall}, 32'd0);
        chk("rst req",      {31'd0, bus.dmem_req}, 32'd0);
        chk("rst ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("rst ld_data",  ld_data, 32'd0);
        chk("rst fault",    {30'd0, fault}, 32'd0);
        chk("rst be",       {28'd0, bus.dmem_be}, 32'd0);
        mem_rden = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack in IDLE is ignored.
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("stray req",      {31'd0, bus.dmem_req}, 32'd0);
        chk("stray ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("stray stall",    {31'd0, stall}, 32'd0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // No ack: timeout after TIMEOUT REQ cycles, or indefinite wait.
        @(negedge clk);
        mem_rden = 1'b1; l_sel = 3'b101; addr = 32'h700;
        @(negedge clk);
`ifdef LSU_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("to req",   {31'd0, bus.dmem_req}, 32'd1);
            chk("to stall", {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        mem_rden = 1'b0;
        #1;
        chk("to drop_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("to stall0",   {31'd0, stall}, 32'd0);
        chk("to fault",    {30'd0, fault}, 32'd2);
        chk("to ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("to ld_data",  ld_data, 32'd0);
`else
        for (int k = 0; k < 10; k++) begin
            chk("wait req",   {31'd0, bus.dmem_req}, 32'd1);
            chk("wait stall", {31'd0, stall}, 32'd1);
            if (k == 9) begin
                bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BAD_F00D;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0; mem_rden = 1'b0;
        #1;
        chk("wait fault",    {30'd0, fault}, 32'd0);
        chk("wait ld_valid", {31'd0, ld_valid}, 32'd1);
        chk("wait ld_data",  ld_data, 32'h0BAD_F00D);
`endif
        @(negedge clk);

        // Reset mid-REQ drops everything immediately.
        mem_rden = 1'b1; l_sel = 3'b101; addr = 32'h600;
        @(negedge clk);
        chk("mid req", {31'd0, bus.dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid rst req",      {31'd0, bus.dmem_req}, 32'd0);
        chk("mid rst stall",    {31'd0, stall}, 32'd0);
        chk("mid rst ld_valid", {31'd0, ld_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_rden = 1'b0;
        @(negedge clk);
        chk("post rst req",      {31'd0, bus.dmem_req}, 32'd0);
        chk("post rst ld_valid", {31'd0, ld_valid}, 32'd0);
        run_vec(mk(1, 0, 3'b101, 2'b00, 32'h604, 32'h0, 32'h1357_9BDF, 0, 2'b00,
                   32'h604, 4'hF, 32'h0, 32'h1357_9BDF), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
